// File: rtl/btn_pkg.sv
// Shared definitions for the button event arbiter: parameter defaults,
// event-id width helper and arbiter state encoding.
package btn_pkg;

    localparam int N_BTN_DEF    = 5;
    localparam int TICK_DIV_DEF = 100000;
    localparam int SAMPLES_DEF  = 3;

    typedef enum logic {
        ARB_IDLE,
        ARB_OFFER
    } arb_state_e;

    function automatic int idw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_lane.sv
// One button lane: 2-flop synchronizer, tick-sampled history and hysteresis
// level. 'rise' is combinational so pending can load on the same edge as level.
module debounce_lane
    import btn_pkg::*;
#(
    parameter int SAMPLES = SAMPLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic               sync1_q;
    logic               sync2_q;
    logic [SAMPLES-1:0] hist_q;
    logic [SAMPLES-1:0] hist_d;
    logic               level_q;
    logic               level_d;

    // Level only moves when the freshly shifted history is unanimous.
    always_comb begin
        hist_d  = hist_q;
        level_d = level_q;
        if (tick) begin
            hist_d = {hist_q[SAMPLES-2:0], sync2_q};
            if (&hist_d) begin
                level_d = 1'b1;
            end else if (~|hist_d) begin
                level_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
    assign rise  = level_d & ~level_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced push-buttons to a single round-robin press-event stream on a
// valid/ready port, with a sticky overrun flag for presses lost while pending.
module button_event_arbiter
    import btn_pkg::*;
#(
    parameter int N_BTN    = N_BTN_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int SAMPLES  = SAMPLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_BTN-1:0]       btn_raw,
    output logic [N_BTN-1:0]       btn_level,
    output logic                   evt_valid,
    output logic [idw(N_BTN)-1:0]  evt_id,
    input  logic                   evt_ready,
    output logic                   overrun,
    input  logic                   overrun_clr
);

    localparam int IDW   = idw(N_BTN);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic [N_BTN-1:0] consume, drop;
    logic             overrun_q, overrun_d;
    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [IDW-1:0]   grant_id;
    logic             grant_found;
    logic             hs;

    assign tick  = (cnt_q == CNT_MAX);
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    for (genvar i = 0; i < N_BTN; i++) begin : g_lane
        debounce_lane #(.SAMPLES(SAMPLES)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .rise  (rise[i])
        );
    end

    assign hs = (state_q == ARB_OFFER) && evt_ready;

    // A press landing on a lane that is being consumed this cycle re-arms it
    // instead of counting as lost.
    always_comb begin
        consume = '0;
        if (hs) begin
            consume[evt_id] = 1'b1;
        end
        drop      = rise & pending_q & ~consume;
        pending_d = (pending_q & ~consume) | rise;
        overrun_d = (|drop) | (overrun_q & ~overrun_clr);
    end

    always_comb begin
        int idx;
        state_d     = state_q;
        id_d        = id_q;
        rr_d        = rr_q;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < N_BTN; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_BTN) begin
                idx = idx - N_BTN;
            end
            if (!grant_found && pending_q[idx]) begin
                grant_found = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
        case (state_q)
            ARB_IDLE: begin
                if (grant_found) begin
                    state_d = ARB_OFFER;
                    id_d    = grant_id;
                end
            end
            ARB_OFFER: begin
                if (evt_ready) begin
                    state_d = ARB_IDLE;
                    rr_d    = (id_q == IDW'(N_BTN - 1)) ? '0 : id_q + IDW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pending_q <= '0;
            overrun_q <= 1'b0;
            state_q   <= ARB_IDLE;
            id_q      <= '0;
            rr_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
            id_q      <= id_d;
            rr_q      <= rr_d;
        end
    end

    assign evt_valid = (state_q == ARB_OFFER);
    assign evt_id    = id_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with N_BTN=4, TICK_DIV=4, SAMPLES=3.
module tb_button_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready;
    logic       overrun;
    logic       overrun_clr;

    always #5 clk = ~clk;

    button_event_arbiter #(.N_BTN(4), .TICK_DIV(4), .SAMPLES(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .evt_valid   (evt_valid),
        .evt_id      (evt_id),
        .evt_ready   (evt_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [1:0] evq[$];
    int   vld_cycles = 0;
    int   stab_err   = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [1:0] pid = 2'd0;

    // Handshake log and offer-stability monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (evt_valid) vld_cycles++;
            if (evt_valid && evt_ready) evq.push_back(evt_id);
            if (pv && !pr && (!evt_valid || evt_id != pid)) stab_err++;
            pv  = evt_valid;
            pr  = evt_ready;
            pid = evt_id;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_level(input int b, input logic val, input int limit,
                              input string name, output int cycles);
        cycles = 0;
        while (btn_level[b] !== val && cycles < limit) begin
            cyc(1);
            cycles++;
        end
        chk(name, {31'b0, btn_level[b] === val}, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        btn_raw = 4'b0000;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [31:0] evq_at(input int j);
        return (evq.size() > j) ? {30'b0, evq[j]} : 32'hFFFF;
    endfunction

    typedef struct {
        logic [3:0] press;
        int         n_ev;
        logic [7:0] ids;   // event j in bits [2j+1:2j]
    } vec_t;

    vec_t vt[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;

        vt[0] = '{4'b1111, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
        vt[1] = '{4'b1010, 2, {2'd0, 2'd0, 2'd3, 2'd1}};
        vt[2] = '{4'b0100, 1, {2'd0, 2'd0, 2'd0, 2'd2}};
        vt[3] = '{4'b1001, 2, {2'd0, 2'd0, 2'd0, 2'd3}};
        vt[4] = '{4'b0011, 2, {2'd0, 2'd0, 2'd0, 2'd1}};
        vt[5] = '{4'b0001, 1, {2'd0, 2'd0, 2'd0, 2'd0}};

        rst_n       = 1'b1;
        btn_raw     = 4'b0000;
        evt_ready   = 1'b0;
        overrun_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_level",   {28'b0, btn_level}, 0);
        chk("rst_valid",   {31'b0, evt_valid}, 0);
        chk("rst_id",      {30'b0, evt_id},    0);
        chk("rst_overrun", {31'b0, overrun},   0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Clean press on button 0
        evt_ready = 1'b1;
        btn_raw   = 4'b0001;
        wait_level(0, 1'b1, 15, "clean_rise", cycles);
        chk("clean_latency_ok", {31'b0, cycles <= 15}, 1);
        cyc(20 - cycles);
        chk("clean_held_events", evq.size(), 1);
        btn_raw = 4'b0000;
        wait_level(0, 1'b0, 20, "clean_fall", cycles);
        cyc(10);
        chk("clean_events", evq.size(), 1);
        chk("clean_id", evq_at(0), 0);

        // Bouncing button 1
        evq.delete();
        for (int i = 0; i < 10; i++) begin
            btn_raw[1] = ~btn_raw[1];
            cyc(3);
        end
        btn_raw[1] = 1'b1;
        cyc(25);
        chk("bounce_level", {31'b0, btn_level[1]}, 1);
        chk("bounce_events", evq.size(), 1);
        chk("bounce_id", evq_at(0), 1);
        chk("bounce_overrun", {31'b0, overrun}, 0);
        btn_raw = 4'b0000;
        wait_level(1, 1'b0, 20, "bounce_fall", cycles);
        cyc(10);

        // Round-robin table from a fresh pointer
        pulse_reset();
        for (int v = 0; v < 6; v++) begin
            evq.delete();
            btn_raw = vt[v].press;
            cyc(40);
            chk($sformatf("rr%0d_level", v), {28'b0, btn_level}, {28'b0, vt[v].press});
            btn_raw = 4'b0000;
            cyc(30);
            chk($sformatf("rr%0d_count", v), evq.size(), vt[v].n_ev);
            for (int j = 0; j < vt[v].n_ev; j++)
                chk($sformatf("rr%0d_id%0d", v, j), evq_at(j), {30'b0, vt[v].ids[2*j +: 2]});
        end

        // Backpressure and overrun on button 2
        pulse_reset();
        evq.delete();
        evt_ready = 1'b0;
        btn_raw = 4'b0100;
        cyc(20);
        chk("bp_valid", {31'b0, evt_valid}, 1);
        chk("bp_id", {30'b0, evt_id}, 2);
        chk("bp_no_overrun_yet", {31'b0, overrun}, 0);
        btn_raw = 4'b0000;
        cyc(20);
        btn_raw = 4'b0100;
        cyc(20);
        btn_raw = 4'b0000;
        cyc(20);
        chk("bp_overrun", {31'b0, overrun}, 1);
        chk("bp_valid_held", {31'b0, evt_valid}, 1);
        chk("bp_id_held", {30'b0, evt_id}, 2);
        overrun_clr = 1'b1;
        cyc(1);
        overrun_clr = 1'b0;
        chk("bp_overrun_clr", {31'b0, overrun}, 0);
        evt_ready = 1'b1;
        cyc(10);
        chk("bp_events", evq.size(), 1);
        chk("bp_event_id", evq_at(0), 2);
        chk("bp_valid_after", {31'b0, evt_valid}, 0);

        // Reset while offering button 3
        evq.delete();
        evt_ready = 1'b0;
        btn_raw = 4'b1000;
        cyc(20);
        chk("ro_valid", {31'b0, evt_valid}, 1);
        chk("ro_id", {30'b0, evt_id}, 3);
        @(posedge clk);
        #3 rst_n = 1'b0;
        btn_raw = 4'b0000;
        #1 chk("ro_async_drop", {31'b0, evt_valid}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        vld_cycles = 0;
        evt_ready  = 1'b1;
        cyc(40);
        chk("ro_no_offer", vld_cycles, 0);
        chk("ro_no_event", evq.size(), 0);
        btn_raw = 4'b1000;
        cyc(20);
        btn_raw = 4'b0000;
        cyc(20);
        chk("ro_new_event", evq.size(), 1);
        chk("ro_new_id", evq_at(0), 3);

        chk("offer_stable", stab_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
